// File: rtl/circuito_exp4_game.sv
// circuito_exp4_game: memory-sequence game with a 16-entry ROM, chaves register, counter and FSM.
// Define DB_7SEG_EN to drive the db_* display buses as active-low 7-segment codes.
module circuito_exp4_game (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] chaves,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_igual,
    output logic       db_iniciar,
    output logic [6:0] db_contagem,
    output logic [6:0] db_memoria,
    output logic [6:0] db_chaves,
    output logic [6:0] db_estado
);
    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        REGISTRA    = 4'h4,
        COMPARACAO  = 4'h5,
        PROXIMO     = 4'h6,
        FIM_ACERTOU = 4'hA,
        FIM_ERROU   = 4'hE
    } state_t;

    localparam logic [3:0] ROM [16] = '{
        4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
        4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100
    };

    state_t     state, next_state;
    logic [3:0] contador, registro, memoria;

`ifdef DB_7SEG_EN
    function automatic logic [6:0] disp(input logic [3:0] v);
        case (v)
            4'h0: disp = 7'b1000000;
            4'h1: disp = 7'b1111001;
            4'h2: disp = 7'b0100100;
            4'h3: disp = 7'b0110000;
            4'h4: disp = 7'b0011001;
            4'h5: disp = 7'b0010010;
            4'h6: disp = 7'b0000010;
            4'h7: disp = 7'b1111000;
            4'h8: disp = 7'b0000000;
            4'h9: disp = 7'b0010000;
            4'hA: disp = 7'b0001000;
            4'hB: disp = 7'b0000011;
            4'hC: disp = 7'b1000110;
            4'hD: disp = 7'b0100001;
            4'hE: disp = 7'b0000110;
            default: disp = 7'b0001110;
        endcase
    endfunction
`else
    function automatic logic [6:0] disp(input logic [3:0] v);
        disp = {3'b000, v};
    endfunction
`endif

    assign memoria     = ROM[contador];
    assign db_igual    = registro == memoria;
    assign db_iniciar  = iniciar;
    assign db_contagem = disp(contador);
    assign db_memoria  = disp(memoria);
    assign db_chaves   = disp(registro);
    assign db_estado   = disp(state);

    always_comb begin
        next_state = INICIAL;
        case (state)
            INICIAL:     next_state = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:  next_state = REGISTRA;
            REGISTRA:    next_state = COMPARACAO;
            COMPARACAO:  next_state = !db_igual ? FIM_ERROU : (contador == 4'hF) ? FIM_ACERTOU : PROXIMO;
            PROXIMO:     next_state = REGISTRA;
            FIM_ACERTOU: next_state = iniciar ? PREPARACAO : FIM_ACERTOU;
            FIM_ERROU:   next_state = iniciar ? PREPARACAO : FIM_ERROU;
            default:     next_state = INICIAL;
        endcase
    end

    // End-state flags are registered from next_state so they track the state register exactly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= INICIAL;
            contador <= '0;
            registro <= '0;
            pronto   <= 1'b0;
            acertou  <= 1'b0;
            errou    <= 1'b0;
        end else begin
            state <= next_state;
            if (state == PREPARACAO) begin
                contador <= '0;
                registro <= '0;
            end
            if (state == REGISTRA) registro <= chaves;
            if (state == PROXIMO) contador <= contador + 4'd1;
            pronto  <= next_state == FIM_ACERTOU || next_state == FIM_ERROU;
            acertou <= next_state == FIM_ACERTOU;
            errou   <= next_state == FIM_ERROU;
        end
    end
endmodule

// File: tb/tb_circuito_exp4_game.sv
// tb_circuito_exp4_game: scoreboarded random and directed games against a rule-level game model.
module tb_circuito_exp4_game;
    logic       clock = 0, reset = 0, iniciar = 0;
    logic [3:0] chaves = 0;
    logic       pronto, acertou, errou, db_igual, db_iniciar;
    logic [6:0] db_contagem, db_memoria, db_chaves, db_estado;

    circuito_exp4_game dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .chaves(chaves),
        .pronto(pronto), .acertou(acertou), .errou(errou), .db_igual(db_igual),
        .db_iniciar(db_iniciar), .db_contagem(db_contagem), .db_memoria(db_memoria),
        .db_chaves(db_chaves), .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic ok;
        int   cnt;
        int   lat;
        int   start;
    } exp_t;

    exp_t       sb [$];
    logic [3:0] rom [16] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0001,
                             4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0100};
    logic [3:0] seq [16];
    int         n_pass = 0, n_tot = 0, cyc = 0, start_c = 0;
    logic       prev_pronto = 0;

    function automatic logic [6:0] disp(input logic [3:0] v);
`ifdef DB_7SEG_EN
        logic [6:0] t [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
                               7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[v];
`else
        return {3'b000, v};
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every rising pronto is matched against the oldest expected game result.
    always @(negedge clock) begin
        if (!reset && pronto && !prev_pronto) begin
            if (sb.size() == 0) chk("unexpected_end", 1, 0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("end_acertou", acertou, e.ok);
                chk("end_errou", errou, !e.ok);
                chk("end_contagem", db_contagem, disp(4'(e.cnt)));
                chk("end_estado", db_estado, disp(e.ok ? 4'hA : 4'hE));
                chk("end_latency", cyc - e.start + 1, e.lat);
            end
        end
        prev_pronto <= pronto;
    end

    task automatic play(input int abort_at);
        int   bad = 16, last;
        exp_t e;
        for (int k = 0; k < 16; k++) if (bad == 16 && seq[k] != rom[k]) bad = k;
        last = (bad == 16) ? 15 : bad;
        @(negedge clock);
        iniciar = 1;
        #1 chk("db_iniciar", db_iniciar, 1);
        @(posedge clock);
        #1 start_c = cyc;
        if (abort_at < 0) begin
            e.ok = (bad == 16); e.cnt = last; e.lat = 3 * last + 4; e.start = start_c;
            sb.push_back(e);
        end
        @(negedge clock);
        chk("prep_estado", db_estado, disp(4'h1));
        chk("prep_pronto", pronto, 0);
        chk("prep_errou", errou, 0);
        iniciar = 0;
        for (int k = 0; k <= last; k++) begin
            chaves = seq[k];
            @(negedge clock);
            chk("reg_estado", db_estado, disp(4'h4));
            chk("reg_contagem", db_contagem, disp(4'(k)));
            if (k == 0) chk("reg_cleared", db_chaves, disp(4'h0));
            @(negedge clock);
            if (k == abort_at) begin
                #3 reset = 1;
                #1 chk("abort_estado", db_estado, disp(4'h0));
                chk("abort_contagem", db_contagem, disp(4'h0));
                chk("abort_chaves", db_chaves, disp(4'h0));
                chk("abort_pronto", pronto, 0);
                @(negedge clock);
                reset = 0;
                return;
            end
            chk("cmp_estado", db_estado, disp(4'h5));
            chk("cmp_igual", db_igual, seq[k] == rom[k]);
            chk("cmp_chaves", db_chaves, disp(seq[k]));
            chk("cmp_memoria", db_memoria, disp(rom[k]));
            @(negedge clock);
            if (k < last) chk("prox_estado", db_estado, disp(4'h6));
        end
        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clock);
        chk("scoreboard_drain", sb.size(), 0);
        repeat (3) @(negedge clock);
        chk("hold_pronto", pronto, 1);
        chk("hold_estado", db_estado, disp(bad == 16 ? 4'hA : 4'hE));
    endtask

    initial begin
        #200000 $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 reset = 1;
        #1 chk("rst_estado", db_estado, disp(4'h0));
        chk("rst_contagem", db_contagem, disp(4'h0));
        chk("rst_chaves", db_chaves, disp(4'h0));
        chk("rst_memoria", db_memoria, disp(4'h1));
        chk("rst_igual", db_igual, 0);
        chk("rst_flags", {pronto, acertou, errou}, 0);
        repeat (2) @(negedge clock);
        reset = 0;
        repeat (5) begin
            @(negedge clock);
            chk("idle_estado", db_estado, disp(4'h0));
            chk("idle_flags", {pronto, acertou, errou}, 0);
            chk("idle_contagem", db_contagem, disp(4'h0));
        end
        foreach (seq[k]) seq[k] = rom[k];
        play(-1);
        seq[0] = 4'b0010;
        play(-1);
        foreach (seq[k]) seq[k] = rom[k];
        seq[5] = 4'b0001;
        play(-1);
        foreach (seq[k]) seq[k] = rom[k];
        play(-1);
        play(7);
        repeat (8) begin
            foreach (seq[k]) seq[k] = ($urandom_range(0, 11) == 0) ? 4'(1 << $urandom_range(0, 3)) : rom[k];
            play(-1);
        end
        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
